// File: rtl/intel_vip_reset_gen_seq_block.sv
// Staged reset sequencer: holds all outputs, waits for PLL lock, then
// releases reset_out[0..NUM_OUTPUTS-1] in order, STAGE_GAP clocks apart.
// Ports: clk, async_reset (async, active-high), pll_locked (async),
//   sw_reset_req (rising edge restarts), reset_out[NUM_OUTPUTS-1:0],
//   reset_done, sw_reset_ack (one-cycle pulse).
// Macro INTEL_VIP_RESET_GEN_LOCK_MONITOR_EN: lock loss after release
//   restarts the sequence; undefined means lock is only checked once.
module intel_vip_reset_gen_seq_block #(
   parameter int NUM_OUTPUTS = 3,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_GAP   = 4
) (
   input  logic                   clk,
   input  logic                   async_reset,
   input  logic                   pll_locked,
   input  logic                   sw_reset_req,
   output logic [NUM_OUTPUTS-1:0] reset_out,
   output logic                   reset_done,
   output logic                   sw_reset_ack
);

   localparam int MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ?
                            HOLD_CYCLES : STAGE_GAP;
   localparam int CW = $clog2(MAX_CNT + 1);
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES);
   localparam logic [CW-1:0] GAP_LD  = CW'(STAGE_GAP);
   localparam logic [CW-1:0] ONE     = CW'(1);

   typedef enum logic [1:0] {
      ST_ASSERT,
      ST_WAIT_LOCK,
      ST_RELEASE,
      ST_DONE
   } state_t;

   state_t                 state, state_nx;
   logic [CW-1:0]          cnt, cnt_nx;
   logic [NUM_OUTPUTS-1:0] rst_nx;
   logic                   ack_nx;
   logic                   lock_meta, lock_s;
   logic                   sw_q;
   logic                   sw_rise;
   logic                   lock_lost;

   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
         sw_q      <= 1'b0;
      end else begin
         lock_meta <= pll_locked;
         lock_s    <= lock_meta;
         sw_q      <= sw_reset_req;
      end
   end

   assign sw_rise = sw_reset_req & ~sw_q;

`ifdef INTEL_VIP_RESET_GEN_LOCK_MONITOR_EN
   assign lock_lost = ~lock_s &
                      ((state == ST_RELEASE) || (state == ST_DONE));
`else
   assign lock_lost = 1'b0;
`endif

   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         state        <= ST_ASSERT;
         cnt          <= HOLD_LD;
         reset_out    <= '1;
         sw_reset_ack <= 1'b0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         reset_out    <= rst_nx;
         sw_reset_ack <= ack_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = (cnt != '0) ? cnt - ONE : cnt;
      rst_nx   = reset_out;
      ack_nx   = 1'b0;
      if (sw_rise) begin
         state_nx = ST_ASSERT;
         cnt_nx   = HOLD_LD;
         rst_nx   = '1;
         ack_nx   = 1'b1;
      end else if (lock_lost) begin
         state_nx = ST_ASSERT;
         cnt_nx   = HOLD_LD;
         rst_nx   = '1;
      end else begin
         unique case (state)
            ST_ASSERT: begin
               rst_nx = '1;
               if (cnt <= ONE) state_nx = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
               if (lock_s) begin
                  state_nx = ST_RELEASE;
                  rst_nx   = reset_out << 1;
                  cnt_nx   = GAP_LD;
               end
            end
            ST_RELEASE: begin
               // top bit already clear: every stage is out
               if (!reset_out[NUM_OUTPUTS-1]) begin
                  state_nx = ST_DONE;
               end else if (cnt <= ONE) begin
                  rst_nx = reset_out << 1;
                  cnt_nx = GAP_LD;
               end
            end
            ST_DONE: rst_nx = '0;
            default: begin
               state_nx = ST_ASSERT;
               cnt_nx   = HOLD_LD;
               rst_nx   = '1;
            end
         endcase
      end
   end

   assign reset_done = (state == ST_DONE);

endmodule
